// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the iterative multiply/accumulate engine.
package seq_mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter must hold values 0..WIDTH/K inclusive.
   function automatic int unsigned cnt_width(input int unsigned width, input int unsigned k);
      return $clog2(width / k + 1);
   endfunction

endpackage

// File: rtl/seq_mul_step.sv
// Combinational partial-product generator: |a| times a K-bit multiplier slice.
module seq_mul_step #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned K     = 1
) (
   input  logic [WIDTH-1:0]   a_mag,
   input  logic [K-1:0]       slice,
   output logic [WIDTH+K-1:0] pp_c
);

   localparam int unsigned PPW = WIDTH + K;

   always_comb begin
      pp_c = '0;
      for (int unsigned i = 0; i < K; i++) begin
         if (slice[i]) pp_c = pp_c + (PPW'(a_mag) << i);
      end
   end

endmodule

// File: rtl/seq_array_multiplier.sv
// Iterative signed/unsigned multiplier with optional running accumulator,
// retiring BITS_PER_CYCLE multiplier bits per clock.
module seq_array_multiplier
   import seq_mul_pkg::*;
#(
   parameter int unsigned WIDTH          = 8,
   parameter int unsigned BITS_PER_CYCLE = 1,
   parameter int unsigned ACC_W          = 2 * WIDTH + 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               is_signed,
   input  logic               acc_en,
   input  logic               acc_clr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic [ACC_W-1:0]   acc_out
);

   localparam int unsigned K  = BITS_PER_CYCLE;
   localparam int unsigned N  = WIDTH / K;
   localparam int unsigned CW = cnt_width(WIDTH, K);
   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned SW = $clog2(PW);

   state_t            state, state_next;
   logic [WIDTH-1:0]  a_mag, b_mag;
   logic              sign_q, signed_q, acc_en_q;
   logic [PW-1:0]     partial;
   logic [CW-1:0]     count;

   logic [WIDTH+K-1:0] step_pp_c;
   logic [SW-1:0]      shamt_c;
   logic [PW-1:0]      partial_nxt_c, prod_fix_c;
   logic signed [PW-1:0] prod_s_c;
   logic [ACC_W-1:0]   prod_ext_c;
   logic               last_c;

   seq_mul_step #(.WIDTH(WIDTH), .K(K)) u_step (
      .a_mag (a_mag),
      .slice (b_mag[K-1:0]),
      .pp_c  (step_pp_c)
   );

   // Partial-product accumulation and final sign fix-up / extension.
   always_comb begin
      shamt_c       = SW'(count) * SW'(K);
      partial_nxt_c = partial + (PW'(step_pp_c) << shamt_c);
      last_c        = (count == CW'(N - 1));
      prod_fix_c    = sign_q ? (~partial_nxt_c + PW'(1)) : partial_nxt_c;
      prod_s_c      = $signed(prod_fix_c);
      if (signed_q) prod_ext_c = ACC_W'(prod_s_c);
      else          prod_ext_c = ACC_W'(prod_fix_c);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid)  state_next = RUN;
         RUN:     if (last_c)    state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand registers, iteration counter, outputs and accumulator.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         a_mag     <= '0;
         b_mag     <= '0;
         sign_q    <= 1'b0;
         signed_q  <= 1'b0;
         acc_en_q  <= 1'b0;
         partial   <= '0;
         count     <= '0;
         product   <= '0;
         acc_out   <= '0;
      end else begin
         in_ready  <= (state_next == IDLE);
         out_valid <= (state_next == DONE);
         case (state)
            IDLE: begin
               if (acc_clr) acc_out <= '0;
               if (in_valid) begin
                  a_mag    <= (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
                  b_mag    <= (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
                  sign_q   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  signed_q <= is_signed;
                  acc_en_q <= acc_en;
                  partial  <= '0;
                  count    <= '0;
               end
            end
            RUN: begin
               partial <= partial_nxt_c;
               b_mag   <= b_mag >> K;
               count   <= count + CW'(1);
               if (last_c) begin
                  product <= prod_fix_c;
                  if (acc_en_q) acc_out <= acc_out + prod_ext_c;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Bench for seq_array_multiplier: three instances (K=1,2,4) against an
// arithmetic reference model of product and accumulator.
module tb_seq_array_multiplier;

   localparam int unsigned W  = 8;
   localparam int unsigned AW = 2 * W + 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          in_valid [3];
   logic          in_ready [3];
   logic [W-1:0]  a [3];
   logic [W-1:0]  b [3];
   logic          is_signed [3];
   logic          acc_en [3];
   logic          acc_clr [3];
   logic          out_valid [3];
   logic          out_ready [3];
   logic [2*W-1:0] product [3];
   logic [AW-1:0] acc_out [3];

   int unsigned nvec = 0;
   int unsigned nmis = 0;
   longint      macc [3];
   int          nlat [3] = '{8, 4, 2};

   seq_array_multiplier #(.WIDTH(W), .BITS_PER_CYCLE(1), .ACC_W(AW)) u_k1 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .a(a[0]), .b(b[0]), .is_signed(is_signed[0]), .acc_en(acc_en[0]),
      .acc_clr(acc_clr[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .product(product[0]), .acc_out(acc_out[0]));

   seq_array_multiplier #(.WIDTH(W), .BITS_PER_CYCLE(2), .ACC_W(AW)) u_k2 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .a(a[1]), .b(b[1]), .is_signed(is_signed[1]), .acc_en(acc_en[1]),
      .acc_clr(acc_clr[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .product(product[1]), .acc_out(acc_out[1]));

   seq_array_multiplier #(.WIDTH(W), .BITS_PER_CYCLE(4), .ACC_W(AW)) u_k4 (
      .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .a(a[2]), .b(b[2]), .is_signed(is_signed[2]), .acc_en(acc_en[2]),
      .acc_clr(acc_clr[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .product(product[2]), .acc_out(acc_out[2]));

   function automatic longint ref_mul(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      if (s) return longint'($signed(x)) * longint'($signed(y));
      return longint'(x) * longint'(y);
   endfunction

   // Reference: returns expected product and updates the modelled accumulator.
   function automatic logic [2*W-1:0] model_op(input int idx, input logic [W-1:0] x,
                                               input logic [W-1:0] y, input logic s,
                                               input logic en, input logic clr);
      longint p;
      p = ref_mul(x, y, s);
      if (clr) macc[idx] = 0;
      if (en)  macc[idx] = (macc[idx] + p) & ((64'sd1 <<< AW) - 1);
      return (2*W)'(p);
   endfunction

   // Drives one operation, optionally holds off out_ready, and reports what it saw.
   task automatic run_op(input int idx, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic ts, input logic ten, input logic tclr, input int hold,
                         output logic [2*W-1:0] p, output logic [AW-1:0] ac,
                         output int lat, output bit stable);
      int n;
      stable = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready[idx] && n < 50) begin @(negedge clk); n++; end
      a[idx] = ta; b[idx] = tb_; is_signed[idx] = ts; acc_en[idx] = ten;
      acc_clr[idx] = tclr; in_valid[idx] = 1'b1;
      @(negedge clk);
      in_valid[idx] = 1'b0; acc_clr[idx] = 1'b0;
      a[idx] = W'($urandom); b[idx] = W'($urandom);
      is_signed[idx] = 1'($urandom); acc_en[idx] = 1'($urandom);
      lat = 0;
      while (out_valid[idx] !== 1'b1 && lat < 100) begin
         if (in_ready[idx] !== 1'b0) stable = 1'b0;
         @(negedge clk);
         lat++;
      end
      p = product[idx];
      ac = acc_out[idx];
      for (int i = 0; i < hold; i++) begin
         in_valid[idx] = 1'b1; a[idx] = W'($urandom); b[idx] = W'($urandom);
         @(negedge clk);
         if (out_valid[idx] !== 1'b1 || product[idx] !== p || acc_out[idx] !== ac ||
             in_ready[idx] !== 1'b0) stable = 1'b0;
      end
      in_valid[idx] = 1'b0;
      out_ready[idx] = 1'b1;
      @(negedge clk);
      out_ready[idx] = 1'b0;
      if (out_valid[idx] !== 1'b0) stable = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         nvec++;
         if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0 || product[i] !== '0 || acc_out[i] !== '0) begin
            nmis++;
            $display("FAIL reset idx=%0d got rdy=%b vld=%b prod=%h acc=%h want 1 0 0 0",
                     i, in_ready[i], out_valid[i], product[i], acc_out[i]);
         end
         macc[i] = 0;
      end
      rst = 1'b0;
   endtask

   task automatic test_unsigned_max();
      logic [2*W-1:0] p; logic [AW-1:0] ac; int lat; bit st;
      run_op(0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 0, p, ac, lat, st);
      void'(model_op(0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0));
      nvec++;
      if (p !== 16'hFE01) begin nmis++; $display("FAIL umax_product got=%h want=fe01", p); end
      nvec++;
      if (lat !== 8) begin nmis++; $display("FAIL umax_latency got=%0d want=8", lat); end
   endtask

   task automatic test_signed();
      logic [W-1:0]   ta [4] = '{8'hFD, 8'h80, 8'h80, 8'h00};
      logic [W-1:0]   tbv [4] = '{8'h05, 8'h80, 8'h7F, 8'hFF};
      logic [2*W-1:0] want [4] = '{16'hFFF1, 16'h4000, 16'hC080, 16'h0000};
      logic [2*W-1:0] p; logic [AW-1:0] ac; int lat; bit st;
      for (int i = 0; i < 4; i++) begin
         run_op(0, ta[i], tbv[i], 1'b1, 1'b0, 1'b0, 0, p, ac, lat, st);
         void'(model_op(0, ta[i], tbv[i], 1'b1, 1'b0, 1'b0));
         nvec++;
         if (p !== want[i]) begin
            nmis++; $display("FAIL signed_product a=%h b=%h got=%h want=%h", ta[i], tbv[i], p, want[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [2*W-1:0] p; logic [AW-1:0] ac; int lat; bit st;
      logic [2*W-1:0] e;
      run_op(0, 8'h0C, 8'hF3, 1'b1, 1'b1, 1'b1, 5, p, ac, lat, st);
      e = model_op(0, 8'h0C, 8'hF3, 1'b1, 1'b1, 1'b1);
      nvec++;
      if (st !== 1'b1) begin nmis++; $display("FAIL backpressure_stable got=%b want=1", st); end
      nvec++;
      if (p !== e) begin nmis++; $display("FAIL backpressure_product got=%h want=%h", p, e); end
      nvec++;
      if (ac !== AW'(macc[0])) begin nmis++; $display("FAIL backpressure_acc got=%h want=%h", ac, AW'(macc[0])); end
   endtask

   task automatic test_accumulate();
      logic [W-1:0] ta [3] = '{8'd10, 8'hF9, 8'd2};
      logic [W-1:0] tbv [3] = '{8'd10, 8'd3, 8'd2};
      logic [2*W-1:0] p; logic [AW-1:0] ac; int lat; bit st;
      for (int i = 0; i < 3; i++) begin
         run_op(0, ta[i], tbv[i], 1'b1, 1'b1, (i == 0), 0, p, ac, lat, st);
         void'(model_op(0, ta[i], tbv[i], 1'b1, 1'b1, (i == 0)));
      end
      nvec++;
      if (ac !== AW'(83)) begin nmis++; $display("FAIL accumulate_83 got=%0d want=83", ac); end
   endtask

   task automatic test_acc_wrap();
      logic [2*W-1:0] p; logic [AW-1:0] ac; int lat; bit st;
      for (int k = 1; k <= 20; k++) begin
         run_op(0, 8'hFF, 8'hFF, 1'b0, 1'b1, (k == 1), 0, p, ac, lat, st);
         void'(model_op(0, 8'hFF, 8'hFF, 1'b0, 1'b1, (k == 1)));
         nvec++;
         if (ac !== AW'(macc[0])) begin
            nmis++; $display("FAIL acc_wrap k=%0d got=%h want=%h", k, ac, AW'(macc[0]));
         end
      end
   endtask

   task automatic test_reset_mid_run();
      logic [2*W-1:0] p; logic [AW-1:0] ac; int lat; bit st;
      bit rose;
      @(negedge clk);
      a[0] = 8'd77; b[0] = 8'd91; is_signed[0] = 1'b0; acc_en[0] = 1'b1; in_valid[0] = 1'b1;
      @(posedge clk);
      repeat (4) @(posedge clk);
      @(negedge clk);
      in_valid[0] = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) macc[i] = 0;
      nvec++;
      if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || acc_out[0] !== '0) begin
         nmis++; $display("FAIL midrun_reset got rdy=%b vld=%b acc=%h want 1 0 0",
                          in_ready[0], out_valid[0], acc_out[0]);
      end
      rose = 1'b0;
      repeat (12) begin @(negedge clk); if (out_valid[0] !== 1'b0) rose = 1'b1; end
      nvec++;
      if (rose) begin nmis++; $display("FAIL midrun_no_output got=1 want=0"); end
      run_op(0, 8'd6, 8'd7, 1'b0, 1'b0, 1'b0, 0, p, ac, lat, st);
      nvec++;
      if (p !== 16'd42) begin nmis++; $display("FAIL after_reset_6x7 got=%0d want=42", p); end
   endtask

   task automatic test_random(input int idx, input int count);
      logic [2*W-1:0] p, e; logic [AW-1:0] ac; int lat; bit st;
      logic [W-1:0] ta, tbv; logic ts, ten, tclr;
      for (int n = 0; n < count; n++) begin
         ta  = ($urandom_range(0, 9) == 0) ? 8'h80 : W'($urandom);
         tbv = ($urandom_range(0, 9) == 0) ? 8'h80 : W'($urandom);
         ts = 1'($urandom); ten = 1'($urandom); tclr = ($urandom_range(0, 7) == 0);
         run_op(idx, ta, tbv, ts, ten, tclr, 0, p, ac, lat, st);
         e = model_op(idx, ta, tbv, ts, ten, tclr);
         nvec++;
         if (p !== e) begin
            nmis++; $display("FAIL rand_product idx=%0d a=%h b=%h s=%b got=%h want=%h", idx, ta, tbv, ts, p, e);
         end
         nvec++;
         if (ac !== AW'(macc[idx])) begin
            nmis++; $display("FAIL rand_acc idx=%0d got=%h want=%h", idx, ac, AW'(macc[idx]));
         end
         nvec++;
         if (lat !== nlat[idx]) begin
            nmis++; $display("FAIL rand_latency idx=%0d got=%0d want=%0d", idx, lat, nlat[idx]);
         end
         nvec++;
         if (st !== 1'b1) begin
            nmis++; $display("FAIL rand_handshake idx=%0d got=%b want=1", idx, st);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid[i] = 1'b0; a[i] = '0; b[i] = '0; is_signed[i] = 1'b0;
         acc_en[i] = 1'b0; acc_clr[i] = 1'b0; out_ready[i] = 1'b0; macc[i] = 0;
      end
      test_reset();
      test_unsigned_max();
      test_signed();
      test_backpressure();
      test_accumulate();
      test_acc_wrap();
      test_reset_mid_run();
      test_random(0, 300);
      test_random(1, 3000);
      test_random(2, 3000);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
